// File: rtl/fdce_bank_pkg.sv
// Shared definitions for the FDCE configuration-bank write scheduler.
//   state_t          : scheduler states (idle, one-cycle write, clear pulse, recovery gap)
//   *_MIN / *_MAX    : legal parameter ranges checked at elaboration
//   max2()           : integer maximum, used for sizing the shared counter
package fdce_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam int NREG_MIN       = 2;
  localparam int NREG_MAX       = 32;
  localparam int CLR_CYCLES_MIN = 1;
  localparam int REC_CYCLES_MIN = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk     : clock, rising edge
//   srst    : synchronous active-high reset (pointer back to requester 0)
//   req     : request vector, bit i = requester i
//   advance : a grant is being taken this cycle; pointer moves to the loser
//   gnt     : one-hot grant (zero when no request)
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr_reg = 0 favours requester 0 on contention, 1 favours requester 1.
  logic ptr_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_reg ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other requester gets priority, even if it was idle.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= 1'b0;
    end else if (advance) begin
      ptr_reg <= gnt[0];
    end
  end

endmodule

// File: rtl/fdce_bank_sched.sv
// Write/clear scheduler for a bank of NREG x WIDTH FDCE configuration registers.
// Sole driver of the bank's CE, D and CLR pins.
//   C, R            : clock (rising edge) and synchronous active-high reset
//   VALIDx/ADDRx/DATAx : write request from requester x (held until READYx)
//   READYx          : request accepted this cycle (only in IDLE)
//   CLR_REQ         : level bulk-clear request, priority over writes
//   CE_O            : one-hot clock enable, high only in the WRITE cycle
//   D_O             : shared data bus, holds its last value outside WRITE
//   CLR_O           : stretched clear pulse, CLR_CYCLES long
//   BUSY            : state is not IDLE
//   ERR             : one-cycle pulse when the written address is out of range
module fdce_bank_sched
  import fdce_bank_pkg::*;
#(
  parameter int NREG       = 8,
  parameter int WIDTH      = 8,
  parameter int AW         = 5,
  parameter int CLR_CYCLES = 2,
  parameter int REC_CYCLES = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             VALID0,
  input  logic             VALID1,
  input  logic [AW-1:0]    ADDR0,
  input  logic [AW-1:0]    ADDR1,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [WIDTH-1:0] DATA1,
  output logic             READY0,
  output logic             READY1,
  input  logic             CLR_REQ,
  output logic [NREG-1:0]  CE_O,
  output logic [WIDTH-1:0] D_O,
  output logic             CLR_O,
  output logic             BUSY,
  output logic             ERR
);

  // Counter holds at most max(CLR_CYCLES, REC_CYCLES)-1.
  localparam int CNT_MAX = max2(CLR_CYCLES, REC_CYCLES);
  localparam int CNT_W   = max2(1, $clog2(CNT_MAX));

  generate
    if (NREG < NREG_MIN || NREG > NREG_MAX || longint'(NREG) > (longint'(1) << AW) ||
        CLR_CYCLES < CLR_CYCLES_MIN || REC_CYCLES < REC_CYCLES_MIN) begin : g_bad_params
      $error("fdce_bank_sched: illegal parameter set");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NREG-1:0]    ce_reg, ce_next;
  logic [WIDTH-1:0]   d_reg, d_next;
  logic               clr_reg, clr_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;

  logic [1:0]         gnt;
  logic               ready_gate;
  logic               accept;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_data;
  logic [NREG-1:0]    addr_dec;
  logic               addr_bad;

  // The handshake is decided in the IDLE cycle itself so that the write lands
  // on the bank in the very next cycle; every pin that reaches the bank is a flop.
  assign ready_gate = (state_reg == ST_IDLE) && !R && !CLR_REQ;
  assign accept     = ready_gate && (VALID0 || VALID1);
  assign READY0     = ready_gate && gnt[0];
  assign READY1     = ready_gate && gnt[1];

  rr_arb2 u_arb (
    .clk     (C),
    .srst    (R),
    .req     ({VALID1, VALID0}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign sel_addr = gnt[1] ? ADDR1 : ADDR0;
  assign sel_data = gnt[1] ? DATA1 : DATA0;

  // Per-register decode; an address past the bank leaves every bit low.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
      assign addr_dec[gi] = (sel_addr == AW'(gi));
    end
  endgenerate
  assign addr_bad = ~|addr_dec;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ce_next    = '0;
    d_next     = d_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_next = ST_CLEAR;
          cnt_next   = CNT_W'(CLR_CYCLES - 1);
        end else if (accept) begin
          // CE/D/ERR are registered here so they are presented during WRITE.
          state_next = ST_WRITE;
          ce_next    = addr_dec;
          d_next     = sel_data;
          err_next   = addr_bad;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_reg == '0) begin
          state_next = ST_RECOVER;
          cnt_next   = CNT_W'(REC_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    clr_next  = (state_next == ST_CLEAR);
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ce_reg    <= '0;
      d_reg     <= '0;
      clr_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ce_reg    <= ce_next;
      d_reg     <= d_next;
      clr_reg   <= clr_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  assign CE_O  = ce_reg;
  assign D_O   = d_reg;
  assign CLR_O = clr_reg;
  assign BUSY  = busy_reg;
  assign ERR   = err_reg;

endmodule

// File: tb/tb_fdce_bank_sched.sv
// Self-checking bench for fdce_bank_sched: expected bank writes are queued when
// a request is accepted and compared when CE_O/ERR appear on the bank side.
module tb_fdce_bank_sched;

  localparam int NREG  = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 5;

  logic             C = 1'b0;
  logic             R = 1'b1;
  logic             VALID0 = 1'b0, VALID1 = 1'b0;
  logic [AW-1:0]    ADDR0 = '0, ADDR1 = '0;
  logic [WIDTH-1:0] DATA0 = '0, DATA1 = '0;
  logic             READY0, READY1;
  logic             CLR_REQ = 1'b0;
  logic [NREG-1:0]  CE_O;
  logic [WIDTH-1:0] D_O;
  logic             CLR_O, BUSY, ERR;

  always #5 C = ~C;

  fdce_bank_sched #(
    .NREG(NREG), .WIDTH(WIDTH), .AW(AW), .CLR_CYCLES(2), .REC_CYCLES(1)
  ) dut (
    .C(C), .R(R),
    .VALID0(VALID0), .VALID1(VALID1),
    .ADDR0(ADDR0), .ADDR1(ADDR1),
    .DATA0(DATA0), .DATA1(DATA1),
    .READY0(READY0), .READY1(READY1),
    .CLR_REQ(CLR_REQ),
    .CE_O(CE_O), .D_O(D_O), .CLR_O(CLR_O), .BUSY(BUSY), .ERR(ERR)
  );

  typedef struct {
    logic [NREG-1:0]  ce;
    logic [WIDTH-1:0] d;
    logic             err;
    int               due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   ptr_m   = 1'b0;

  always @(posedge C) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] dd, input int due);
    exp_t e;
    e.ce  = (int'(a) < NREG) ? (NREG'(1) << a) : '0;
    e.d   = dd;
    e.err = (int'(a) >= NREG);
    e.due = due;
    return e;
  endfunction

  // Bank-side monitor: every CE pulse or ERR pulse must match the next queued write.
  always @(negedge C) begin
    if (CE_O !== '0 || ERR === 1'b1) begin
      if (CE_O !== '0) chk("ce_vs_clr", 32'(CLR_O), 32'(0));
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {23'd0, ERR, CE_O}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_ce", 32'(CE_O), 32'(mon_e.ce));
        chk("wr_d", 32'(D_O), 32'(mon_e.d));
        chk("wr_err", 32'(ERR), 32'(mon_e.err));
        chk("wr_cycle", 32'(cyc), 32'(mon_e.due));
        $display("[TB] write ce=0x%02h d=0x%02h err=%0d at cycle %0d", CE_O, D_O, ERR, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  // Drives one request and waits (bounded) for its READY; returns the wait in cycles.
  task automatic do_req(input int who, input logic [AW-1:0] a, input logic [WIDTH-1:0] dd,
                        input string tag, output int lat);
    bit got = 1'b0;
    lat = -1;
    if (who == 0) begin VALID0 = 1'b1; ADDR0 = a; DATA0 = dd; end
    else          begin VALID1 = 1'b1; ADDR1 = a; DATA1 = dd; end
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge C);
      if (((who == 0) ? READY0 : READY1) === 1'b1) begin
        got = 1'b1;
        lat = k;
        sb_q.push_back(mk_exp(a, dd, cyc + 1));
        ptr_m = (who == 0);
        $display("[TB] %s: req%0d addr=%0d data=0x%02h accepted at cycle %0d", tag, who, a, dd, cyc);
      end
    end
    chk({tag, "_ready"}, 32'(got), 32'(1));
    @(posedge C); #1;
    VALID0 = 1'b0;
    VALID1 = 1'b0;
  endtask

  initial begin
    int         lat;
    int         ngr;
    logic [1:0] exp_g;
    logic       g0;

    // Reset: a pending request must not be acknowledged while R is high.
    VALID0 = 1'b1; ADDR0 = 5'd3;
    repeat (3) @(posedge C);
    @(negedge C);
    chk("rst_ready0", 32'(READY0), 32'(0));
    chk("rst_ready1", 32'(READY1), 32'(0));
    chk("rst_ce", 32'(CE_O), 32'(0));
    chk("rst_d", 32'(D_O), 32'(0));
    chk("rst_clr", 32'(CLR_O), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_err", 32'(ERR), 32'(0));
    $display("[TB] reset outputs checked");
    @(posedge C); #1;
    R = 1'b0; VALID0 = 1'b0;
    idle(1);

    // Contention: both requesters valid every cycle, grants alternate from 0.
    VALID0 = 1'b1; ADDR0 = 5'd1; DATA0 = 8'h10;
    VALID1 = 1'b1; ADDR1 = 5'd2; DATA1 = 8'h20;
    ngr = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge C);
      if (READY0 === 1'b1 || READY1 === 1'b1) begin
        exp_g = ptr_m ? 2'b10 : 2'b01;
        chk("arb_gnt", 32'({READY1, READY0}), 32'(exp_g));
        g0 = READY0;
        if (g0) sb_q.push_back(mk_exp(ADDR0, DATA0, cyc + 1));
        else    sb_q.push_back(mk_exp(ADDR1, DATA1, cyc + 1));
        $display("[TB] arb: grant to req%0d at cycle %0d", g0 ? 0 : 1, cyc);
        ptr_m = g0;
        ngr++;
        @(posedge C); #1;
        if (g0) DATA0 = DATA0 + 8'd1;
        else    DATA1 = DATA1 + 8'd1;
      end
    end
    chk("arb_count", 32'(ngr), 32'(8));
    @(posedge C); #1;
    VALID0 = 1'b0; VALID1 = 1'b0;
    idle(1);

    // Single write: READY at once, CE=0x08 / D=0xA5 next cycle, D holds afterwards.
    do_req(0, 5'd3, 8'hA5, "single", lat);
    chk("single_lat", 32'(lat), 32'(0));
    @(negedge C);
    chk("single_busy_w", 32'(BUSY), 32'(1));
    @(negedge C);
    chk("single_busy_i", 32'(BUSY), 32'(0));
    chk("single_d_hold", 32'(D_O), 32'(8'hA5));
    idle(1);

    // Out of range address: READY1, then CE=0 with a one-cycle ERR.
    do_req(1, 5'd9, 8'h3C, "oor", lat);
    @(negedge C);
    chk("oor_err_on", 32'(ERR), 32'(1));
    chk("oor_ce", 32'(CE_O), 32'(0));
    @(negedge C);
    chk("oor_err_off", 32'(ERR), 32'(0));
    idle(1);

    // Clear and write requested together: clear wins, write follows the recovery gap.
    CLR_REQ = 1'b1; VALID0 = 1'b1; ADDR0 = 5'd5; DATA0 = 8'h5A;
    @(negedge C);
    chk("cvw_no_ready", 32'(READY0), 32'(0));
    @(posedge C); #1;
    CLR_REQ = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge C);
      chk("cvw_clr", 32'(CLR_O), 32'(k <= 2));
      chk("cvw_busy", 32'(BUSY), 32'(k <= 3));
      chk("cvw_ready", 32'(READY0), 32'(k == 4));
      if (READY0 === 1'b1) begin
        sb_q.push_back(mk_exp(5'd5, 8'h5A, cyc + 1));
        ptr_m = 1'b1;
        $display("[TB] cvw: write accepted after clear at cycle %0d", cyc);
      end
    end
    @(posedge C); #1;
    VALID0 = 1'b0;
    idle(2);

    // Clear arriving during WRITE: CE pulse unchanged, CLR_O two cycles later.
    do_req(1, 5'd0, 8'h77, "cdw", lat);
    CLR_REQ = 1'b1;
    @(negedge C);
    chk("cdw_clr_w", 32'(CLR_O), 32'(0));
    @(negedge C);
    chk("cdw_clr_i", 32'(CLR_O), 32'(0));
    @(posedge C); #1;
    CLR_REQ = 1'b0;
    @(negedge C);
    chk("cdw_clr_1", 32'(CLR_O), 32'(1));
    @(negedge C);
    chk("cdw_clr_2", 32'(CLR_O), 32'(1));
    @(negedge C);
    chk("cdw_rec_clr", 32'(CLR_O), 32'(0));
    chk("cdw_rec_busy", 32'(BUSY), 32'(1));
    @(negedge C);
    chk("cdw_idle_busy", 32'(BUSY), 32'(0));
    $display("[TB] cdw: clear after write sequenced");
    idle(1);

    // Reset in the first CLEAR cycle aborts the clear; a write follows immediately.
    CLR_REQ = 1'b1;
    @(negedge C);
    @(posedge C); #1;
    R = 1'b1; CLR_REQ = 1'b0;
    @(negedge C);
    chk("rmc_clr_started", 32'(CLR_O), 32'(1));
    @(posedge C); #1;
    R = 1'b0; ptr_m = 1'b0;
    VALID0 = 1'b1; ADDR0 = 5'd7; DATA0 = 8'hE1;
    @(negedge C);
    chk("rmc_clr_off", 32'(CLR_O), 32'(0));
    chk("rmc_busy", 32'(BUSY), 32'(0));
    chk("rmc_ready", 32'(READY0), 32'(1));
    if (READY0 === 1'b1) begin
      sb_q.push_back(mk_exp(5'd7, 8'hE1, cyc + 1));
      $display("[TB] rmc: write accepted after reset at cycle %0d", cyc);
    end
    @(posedge C); #1;
    VALID0 = 1'b0;
    idle(3);
    @(negedge C);
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
